sort_frame_ctrl: RTL
====================

# sort_frame_ctrl

Host-side controller for the rank sorter (`fsm_sort`). It drives the sorter's `start`/`data_in` side and consumes its `done`/`data_sorted` side. It collects N words from a valid/ready input stream into a parallel frame, fires one sort, waits for completion (with timeout), and returns the sorted frame as a valid/ready output stream.

## Interface
- `N`, default 6: words per frame; must match the sorter's N.
- `WIDTH`, default 8: word width in bits.
- `TIMEOUT`, default 64: maximum WAIT cycles before abort; ≥ 8.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  controller accepts an input word.
- `in_data`  in  WIDTH  input word.
- `sort_start`  out  1  start pulse to the sorter.
- `sort_data_in`  out  WIDTH x [N]  registered frame to the sorter.
- `sort_done`  in  1  sorter completion.
- `sort_data_out`  in  WIDTH x [N]  sorted frame from the sorter.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accepts an output word.
- `out_data`  out  WIDTH  output word.
- `out_last`  out  1  marks the final word of a frame.
- `busy`  out  1  high in any state other than LOAD.
- `timeout_err`  out  1  one-cycle pulse when a sort is aborted.

## Operation
- States: LOAD, FIRE, WAIT, DRAIN.
- LOAD:
  - `in_ready` = 1.
  - On `in_valid && in_ready`, write `in_data` to `frame[ld_cnt]` and increment `ld_cnt`.
  - On acceptance of word N-1, go to FIRE and clear `ld_cnt`.
  - Word order is arrival order; index 0 is the first word.
- FIRE:
  - `sort_start` = 1 for exactly this cycle.
  - `in_ready` = 0.
  - Next state is WAIT unconditionally.
- WAIT:
  - `sort_start` = 0.
  - `wait_cnt` increments each cycle.
  - When `sort_done` = 1, capture `sort_data_out` into `obuf`, clear `wait_cnt`, and go to DRAIN.
  - When `wait_cnt` == TIMEOUT-1 and `sort_done` = 0, pulse `timeout_err`, clear `wait_cnt`, and go to LOAD. `frame` is kept but will be overwritten by the next frame.
  - If `sort_done` and the timeout fire in the same cycle, `sort_done` wins.
- DRAIN:
  - `out_valid` = 1, `out_data` = `obuf[out_cnt]`, `out_last` = (`out_cnt` == N-1).
  - On `out_valid && out_ready`, increment `out_cnt`.
  - After the last word is accepted, clear `out_cnt` and go to LOAD.
- `sort_done` outside WAIT is ignored.
- `sort_data_in` is driven continuously from `frame`.
- Counter widths: `ld_cnt` and `out_cnt` are $clog2(N) bits; `wait_cnt` is $clog2(TIMEOUT) bits. No wrap-around occurs: each counter clears explicitly when it reaches its terminal value.

## Timing
- Reset values:
  - state = LOAD, all counters = 0, `frame` = `obuf` = 0.
  - `in_ready` = 0 while `rst` = 0, then 1 from the first cycle after release.
  - `sort_start`, `out_valid`, `out_last`, `timeout_err` = 0.
  - `busy` = 0, `out_data` = 0.
- All outputs are decoded from registered state, counters and buffers. There is no combinational path from `in_valid` or `out_ready` to any output.
- The last input word is accepted at edge T. Then:
  - `sort_start` is high in cycle T+1;
  - WAIT begins at T+2;
  - the sorter sees a clean rising edge because `sort_start` is low both before and after the pulse.
- `sort_done` sampled high at edge D puts the first `out_valid` high in cycle D+1.
- With `out_ready` held at 1, N output beats take N consecutive cycles, and `in_ready` rises the cycle after the last beat.
- While `out_valid` = 1 and `out_ready` = 0, `out_data` and `out_last` hold stable.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock. Any partial frame is dropped.

## Structure
- Shared package `sort_pkg` holds:
  - the `sort_frame_state_t` enum (LOAD, FIRE, WAIT, DRAIN), 2 bits;
  - default constants `SORT_N` = 6 and `SORT_WIDTH` = 8, shared with the sorter.
- The block is a single module with no sub-modules. The top level instantiates it next to the sorter and wires the `sort_*` ports directly.

## Test plan
Bench settings: N=6, WIDTH=8, TIMEOUT=16. A behavioural sorter model asserts done 5 cycles after the start pulse.
- **Basic sort:** feed 5,3,9,1,7,2 with `out_ready`=1. Required: `sort_data_in` = {5,3,9,1,7,2}; `sort_start` high exactly 1 cycle; output 1,2,3,5,7,9 on consecutive cycles; `out_last` only on 9.
- **Output backpressure:** drive `out_ready` = 1,0,1,0,... Required: every beat is held stable while stalled; exactly 6 beats; no duplicates or drops.
- **Timeout:** the model never asserts done. Required: `timeout_err` pulses in WAIT cycle 16; `in_ready` = 1 the next cycle; no `out_valid`.
- **Reset mid-drain:** drive `rst` = 0 after 3 beats have been accepted. Required: `out_valid` = 0 and `busy` = 0 asynchronously. The next frame 8,8,0,255,4,4 then outputs 0,4,4,8,8,255.
- **Spurious done and input gaps:** pulse `sort_done` during LOAD, and apply `in_valid` with gaps. Required: no state change and the frame loads correctly.
- **Back-to-back frames:** hold `in_valid` high throughout. Required: `in_ready` = 0 from FIRE until the last output beat; the second frame is accepted intact.

Source files
------------

// File: rtl/sort_pkg.sv
// sort_pkg: state encoding and default sizes shared by the sort frame controller and the sorter
package sort_pkg;

   localparam int SORT_N     = 6;
   localparam int SORT_WIDTH = 8;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      FIRE  = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } sort_frame_state_t;

endpackage

// File: rtl/sort_frame_ctrl.sv
// sort_frame_ctrl: gathers N stream words into a frame, fires one sort, streams the sorted frame back out
//   clk, rst                               : clock, asynchronous active-low reset
//   in_valid, in_ready, in_data            : input word stream
//   sort_start, sort_data_in               : start pulse and registered frame towards the sorter
//   sort_done, sort_data_out               : completion and sorted frame from the sorter
//   out_valid, out_ready, out_data, out_last : sorted output word stream
//   busy, timeout_err                      : not-in-LOAD status, one-cycle abort pulse
module sort_frame_ctrl
   import sort_pkg::*;
#(
   parameter int N       = SORT_N,
   parameter int WIDTH   = SORT_WIDTH,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   output logic               sort_start,
   output logic [N*WIDTH-1:0] sort_data_in,
   input  logic               sort_done,
   input  logic [N*WIDTH-1:0] sort_data_out,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_last,
   output logic               busy,
   output logic               timeout_err
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST  = CW'(N - 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   sort_frame_state_t  state_q, state_d;
   logic [CW-1:0]      ld_cnt_q, ld_cnt_d, out_cnt_q, out_cnt_d;
   logic [TW-1:0]      wait_cnt_q, wait_cnt_d;
   logic [N*WIDTH-1:0] frame_q, frame_d, obuf_q, obuf_d;
   // Holds in_ready low while in reset and releases it on the first edge afterwards
   logic               arm_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= LOAD;
         ld_cnt_q   <= '0;
         out_cnt_q  <= '0;
         wait_cnt_q <= '0;
         frame_q    <= '0;
         obuf_q     <= '0;
         arm_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ld_cnt_q   <= ld_cnt_d;
         out_cnt_q  <= out_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         frame_q    <= frame_d;
         obuf_q     <= obuf_d;
         arm_q      <= 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      ld_cnt_d    = ld_cnt_q;
      out_cnt_d   = out_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      frame_d     = frame_q;
      obuf_d      = obuf_q;
      in_ready    = 1'b0;
      sort_start  = 1'b0;
      out_valid   = 1'b0;
      out_data    = '0;
      out_last    = 1'b0;
      timeout_err = 1'b0;
      case (state_q)
         LOAD: begin
            in_ready = arm_q;
            if (in_valid && arm_q) begin
               frame_d[ld_cnt_q*WIDTH +: WIDTH] = in_data;
               ld_cnt_d = (ld_cnt_q == LAST) ? '0 : ld_cnt_q + 1'b1;
               state_d  = (ld_cnt_q == LAST) ? FIRE : LOAD;
            end
         end
         FIRE: begin
            sort_start = 1'b1;
            state_d    = WAIT;
         end
         WAIT: begin
            // A done arriving on the timeout cycle still completes the sort
            if (sort_done) begin
               obuf_d     = sort_data_out;
               wait_cnt_d = '0;
               state_d    = DRAIN;
            end else if (wait_cnt_q == TLAST) begin
               timeout_err = 1'b1;
               wait_cnt_d  = '0;
               state_d     = LOAD;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         DRAIN: begin
            out_valid = 1'b1;
            out_data  = obuf_q[out_cnt_q*WIDTH +: WIDTH];
            out_last  = out_cnt_q == LAST;
            if (out_ready) begin
               out_cnt_d = (out_cnt_q == LAST) ? '0 : out_cnt_q + 1'b1;
               state_d   = (out_cnt_q == LAST) ? LOAD : DRAIN;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   assign sort_data_in = frame_q;
   assign busy         = state_q != LOAD;

endmodule
